// File: rtl/handshake_sender.sv
// handshake_sender: serial transmitter for handshake frames (sync word + 8-bit header + 4 check bits).
// Optional inter-frame gap enabled by defining HND_SENDER_GAP_EN.
module handshake_sender #(
  parameter int unsigned              SYNC_BITS    = 11,
  parameter logic [SYNC_BITS-1:0]     SYNC_WORD    = 11'b11100010010,
  parameter int unsigned              CLKS_PER_BIT = 4,
  parameter int unsigned              GAP_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       game_active,
  input  logic       send_ack,
  input  logic       ack_seqnum,
  input  logic       send_lost,
  output logic       serial_out_h,
  output logic       busy,
  output logic       send_done,
  output logic [3:0] frames_sent
);

  localparam int unsigned ENC_BITS = 12;
  localparam int unsigned SHIFT_W  = SYNC_BITS + ENC_BITS - 1;
  localparam int unsigned MAX_BITS = (SYNC_BITS > ENC_BITS)
                                     ? ((SYNC_BITS > GAP_BITS) ? SYNC_BITS : GAP_BITS)
                                     : ((ENC_BITS > GAP_BITS) ? ENC_BITS : GAP_BITS);
  localparam int unsigned BIT_W    = $clog2(MAX_BITS);
  localparam int unsigned BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HEAD = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [SHIFT_W-1:0]   shreg_q, shreg_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pend_ack_q, pend_ack_d;
  logic                 pend_lost_q, pend_lost_d;
  logic                 seq_q, seq_d;
  logic                 req_ack_c, req_lost_c;
  logic                 bit_end_c;
  logic                 launch_c;
  logic [ENC_BITS-1:0]  enc_c;

  // Header {4{seq},4{pid}} followed by nibble-xor check bits.
  function automatic logic [ENC_BITS-1:0] encode(input logic seq, input logic pid);
    logic [7:0] hdr;
    hdr = {{4{seq}}, {4{pid}}};
    return {hdr, hdr[7:4] ^ hdr[3:0]};
  endfunction

  assign req_ack_c  = send_ack & game_active;
  assign req_lost_c = send_lost & game_active;
  assign bit_end_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  assign serial_out_h = line_q;
  assign busy         = busy_q;
  assign send_done    = done_q;
  assign frames_sent  = cnt_q;

  // State, baud/bit counters, shift register, request queue and outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      line_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      pend_ack_q  <= 1'b0;
      pend_lost_q <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      pend_ack_q  <= pend_ack_d;
      pend_lost_q <= pend_lost_d;
      seq_q       <= seq_d;
    end
  end

  // Next-state: request capture, bit timing, frame end and launch of the next queued frame.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    line_d      = line_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    pend_ack_d  = pend_ack_q | req_ack_c;
    pend_lost_d = pend_lost_q | req_lost_c;
    seq_d       = req_ack_c ? ack_seqnum : seq_q;
    launch_c    = 1'b0;
    enc_c       = '0;

    if (!game_active) begin
      // Abort: drop everything, including the frame counter.
      state_d     = ST_IDLE;
      baud_d      = '0;
      bit_d       = '0;
      line_d      = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = '0;
      pend_ack_d  = 1'b0;
      pend_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          line_d   = 1'b0;
          busy_d   = 1'b0;
          launch_c = pend_ack_d | pend_lost_d;
        end
        ST_SYNC, ST_HEAD: begin
          if (!bit_end_c) begin
            baud_d = baud_q + BAUD_W'(1);
          end else begin
            baud_d  = '0;
            line_d  = shreg_q[SHIFT_W-1];
            shreg_d = {shreg_q[SHIFT_W-2:0], 1'b0};
            if ((state_q == ST_SYNC) && (bit_q == BIT_W'(SYNC_BITS - 1))) begin
              state_d = ST_HEAD;
              bit_d   = '0;
            end else if ((state_q == ST_HEAD) && (bit_q == BIT_W'(ENC_BITS - 1))) begin
              done_d = 1'b1;
              cnt_d  = cnt_q + 4'd1;
              bit_d  = '0;
              line_d = 1'b0;
`ifdef HND_SENDER_GAP_EN
              state_d = ST_GAP;
`else
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              launch_c = pend_ack_d | pend_lost_d;
`endif
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
`ifdef HND_SENDER_GAP_EN
        ST_GAP: begin
          line_d = 1'b0;
          if (!bit_end_c) begin
            baud_d = baud_q + BAUD_W'(1);
          end else begin
            baud_d = '0;
            if (bit_q == BIT_W'(GAP_BITS - 1)) begin
              bit_d    = '0;
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              launch_c = pend_ack_d | pend_lost_d;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          line_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Launch: lost has priority; first sync bit goes on the line next cycle.
    if (launch_c) begin
      if (pend_lost_d) begin
        enc_c       = encode(1'b0, 1'b0);
        pend_lost_d = 1'b0;
      end else begin
        enc_c      = encode(seq_d, 1'b1);
        pend_ack_d = 1'b0;
      end
      state_d = ST_SYNC;
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
      line_d  = SYNC_WORD[SYNC_BITS-1];
      shreg_d = {SYNC_WORD[SYNC_BITS-2:0], enc_c};
    end
  end

endmodule
